// File: rtl/itof_pipe_pkg.sv
// Shared FPU constants and stage payload types for the int-to-float pipeline.
// Also provides the field packer for single-precision results.
package itof_pipe_pkg;

    localparam int FP_BIAS = 127;
    localparam int FP_EW   = 8;
    localparam int FP_MW   = 23;
    localparam int INT_W   = 32;

    localparam logic RM_TRUNC = 1'b0;
    localparam logic RM_NEAR  = 1'b1;

    // Exponent of a value whose leading one sits at bit INT_W-1
    localparam logic [FP_EW-1:0] EXP_MAX = FP_EW'(FP_BIAS + INT_W - 1);

    typedef struct packed {
        logic             s;
        logic             rm;
        logic [INT_W-1:0] mag;
    } s1_t;

    typedef struct packed {
        logic             s;
        logic             rm;
        logic             zero;
        logic [5:0]       lz;
        logic [INT_W-1:0] norm;
    } s2_t;

    function automatic logic [31:0] fp_pack(input logic s,
                                            input logic [FP_EW-1:0] e,
                                            input logic [FP_MW-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// Operand/result handshake bundle for itof_pipe.
// The inexact flag exists only when ITOF_INEXACT_EN is defined.
interface itof_pipe_if;

    logic [31:0] x;
    logic        rm;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;

`ifdef ITOF_INEXACT_EN
    logic        inexact;

    modport master (
        output x, rm, in_valid, out_ready,
        input  in_ready, y, out_valid, inexact
    );

    modport slave (
        input  x, rm, in_valid, out_ready,
        output in_ready, y, out_valid, inexact
    );
`else
    modport master (
        output x, rm, in_valid, out_ready,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  x, rm, in_valid, out_ready,
        output in_ready, y, out_valid
    );
`endif

endinterface

// File: rtl/itof_pipe_lzc32.sv
// Combinational leading-zero counter, 32-bit input; returns 32 for an all-zero input.
// Kept standalone so other FPU normalisers can reuse it.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Highest set bit wins because it is visited last
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 single converter with valid/ready on both sides.
// Optional inexact flag output is built when ITOF_INEXACT_EN is defined.
module itof_pipe
    import itof_pipe_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input logic        clk,
    input logic        rstn,
    itof_pipe_if.slave bus
);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic             sgn;
    logic [5:0]       lz;
    logic             g;
    logic             round_up;
    logic [FP_MW:0]   frac_sum;
    logic [FP_EW-1:0] e_base;
    logic [FP_EW-1:0] e_fin;
    logic [31:0]      y_d;
    logic [31:0]      y_q;
    logic             norm_unused;

    // A stage may load when it is empty or its content moves on this edge
    assign ld3 = !v3 || bus.out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3;
    assign bus.y         = y_q;

    // S1: sign/magnitude split; -0x80000000 wraps back to 0x80000000 as wanted
    assign sgn = SIGNED && bus.x[31];

    always_comb begin
        s1_d.s   = sgn;
        s1_d.rm  = bus.rm;
        s1_d.mag = sgn ? -bus.x : bus.x;
    end

    // S2: normalise so the leading one lands on bit 31
    lzc32 u_lzc (
        .a   (s1_q.mag),
        .cnt (lz)
    );

    always_comb begin
        s2_d.s    = s1_q.s;
        s2_d.rm   = s1_q.rm;
        s2_d.zero = (s1_q.mag == '0);
        s2_d.lz   = lz;
        s2_d.norm = s1_q.mag << lz;
    end

    // S3: round and pack; a fraction carry bumps the exponent and leaves zeros behind
    always_comb begin
        g        = s2_q.norm[7];
        round_up = (s2_q.rm == RM_NEAR) && g;
        frac_sum = {1'b0, s2_q.norm[30:8]} + {{FP_MW{1'b0}}, round_up};
        e_base   = EXP_MAX - {2'b00, s2_q.lz};
        e_fin    = e_base + {{(FP_EW-1){1'b0}}, frac_sum[FP_MW]};
        y_d      = s2_q.zero ? '0 : fp_pack(s2_q.s, e_fin, frac_sum[FP_MW-1:0]);
    end

`ifdef ITOF_INEXACT_EN
    logic inx_d;
    logic inx_q;

    assign inx_d       = (g || (|s2_q.norm[6:0])) && !s2_q.zero;
    assign bus.inexact = inx_q;
    assign norm_unused = s2_q.norm[31];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inx_q <= 1'b0;
        end else if (ld3 && v2) begin
            inx_q <= inx_d;
        end
    end
`else
    assign norm_unused = ^{s2_q.norm[31], s2_q.norm[6:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            y_q <= '0;
        end else begin
            if (ld1) v1 <= bus.in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld3 && v2) y_q <= y_d;
        end
    end

    // Payload registers only move under their valid, so they need no reset
    always_ff @(posedge clk) begin
        if (ld1 && bus.in_valid) s1_q <= s1_d;
        if (ld2 && v1)           s2_q <= s2_d;
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: signed and unsigned instances share one stimulus stream.
// Expected results come from an arithmetic model of binary32 conversion with tie-away rounding.
module tb_itof_pipe;
    import itof_pipe_pkg::*;

    typedef struct packed {
        logic [31:0] y;
        logic        inx;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic [31:0] x_d      = '0;
    logic        rm_d     = 1'b0;
    logic        iv_d     = 1'b0;
    logic        or_fix   = 1'b1;
    logic        or_rnd   = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        or_d;

    int checks = 0;
    int errors = 0;

    exp_t sb[2][$];

    logic [1:0]  ov;
    logic [1:0]  irdy;
    logic [1:0]  inxv;
    logic [31:0] yv[2];
    logic [1:0]  prev_stall = '0;
    logic [31:0] prev_y[2];

    always #5 clk = ~clk;

    itof_pipe_if bus_s ();
    itof_pipe_if bus_u ();

    assign or_d = rnd_mode ? or_rnd : or_fix;

    assign bus_s.x = x_d;  assign bus_s.rm = rm_d;  assign bus_s.in_valid = iv_d;  assign bus_s.out_ready = or_d;
    assign bus_u.x = x_d;  assign bus_u.rm = rm_d;  assign bus_u.in_valid = iv_d;  assign bus_u.out_ready = or_d;

    itof_pipe #(.SIGNED(1'b1)) dut_s (.clk(clk), .rstn(rstn), .bus(bus_s.slave));
    itof_pipe #(.SIGNED(1'b0)) dut_u (.clk(clk), .rstn(rstn), .bus(bus_u.slave));

    assign ov    = {bus_u.out_valid, bus_s.out_valid};
    assign irdy  = {bus_u.in_ready, bus_s.in_ready};
    assign yv[0] = bus_s.y;
    assign yv[1] = bus_u.y;
`ifdef ITOF_INEXACT_EN
    assign inxv = {bus_u.inexact, bus_s.inexact};
`else
    assign inxv = '0;
`endif

    always @(posedge clk) begin
        #1;
        or_rnd = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Exact value -> binary32: find the leading power of two, keep 24 significant bits,
    // round the discarded remainder (ties away) when rm selects nearest.
    function automatic exp_t ref_model(input logic [31:0] x, input logic rm, input bit sgn);
        exp_t   r;
        longint v, mag, mant, rem, half;
        int     p, sh;
        bit     neg;
        r.y   = '0;
        r.inx = 1'b0;
        v   = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        neg = (v < 0);
        mag = neg ? -v : v;
        if (mag == 0) return r;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        rem = 0;
        if (p <= 23) begin
            mant = mag << (23 - p);
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag - (mant << sh);
            half = longint'(1) << (sh - 1);
            if (rm && rem >= half) mant++;
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                p++;
            end
        end
        r.y   = {neg, 8'(p + 127), mant[22:0]};
        r.inx = (rem != 0);
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rstn) begin
            prev_stall = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (prev_stall[k]) begin
                    check($sformatf("stall_valid_dut%0d", k), 32'(ov[k]), 32'd1);
                    check($sformatf("stall_y_dut%0d", k), yv[k], prev_y[k]);
                end
                if (ov[k] && or_d) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out_dut%0d: got y=%h expected no output", k, yv[k]);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("y_dut%0d", k), yv[k], e.y);
`ifdef ITOF_INEXACT_EN
                        check($sformatf("inexact_dut%0d", k), 32'(inxv[k]), 32'(e.inx));
`endif
                    end
                end
                prev_stall[k] = ov[k] && !or_d;
                prev_y[k]     = yv[k];
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [31:0] x, input logic rm, input exp_t es, input exp_t eu);
        int n;
        x_d  = x;
        rm_d = rm;
        iv_d = 1'b1;
        n    = 0;
        @(negedge clk);
        while (!irdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!irdy[0]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            sb[0].push_back(es);
            sb[1].push_back(eu);
        end
        @(posedge clk);
        #1;
        iv_d = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] x, input logic rm);
        send(x, rm, ref_model(x, rm, 1'b1), ref_model(x, rm, 1'b0));
    endtask

    task automatic latency_probe(input logic [31:0] x, input logic rm);
        int n;
        send_m(x, rm);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov[0] && n < 20);
        check("latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(sb[0].size() + sb[1].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dx[10]  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000,
                             32'h7FFFFFFF, 32'h7FFFFFFF, 32'h01000001, 32'h01000001, 32'h01000003};
    logic        drm[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] dys[10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000, 32'hCF000000,
                             32'h4EFFFFFF, 32'h4F000000, 32'h4B800000, 32'h4B800001, 32'h4B800002};
    logic [31:0] dyu[10] = '{32'h3F800000, 32'h4F7FFFFF, 32'h00000000, 32'h00000000, 32'h4F000000,
                             32'h4EFFFFFF, 32'h4F000000, 32'h4B800000, 32'h4B800001, 32'h4B800002};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t        es, eu;
        logic [31:0] rx;
        int          sel;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out_valid_dut%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_y_dut%0d", k), yv[k], 32'd0);
            check($sformatf("rst_in_ready_dut%0d", k), 32'(irdy[k]), 32'd1);
`ifdef ITOF_INEXACT_EN
            check($sformatf("rst_inexact_dut%0d", k), 32'(inxv[k]), 32'd0);
`endif
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        latency_probe(32'h00000001, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) begin
            es   = ref_model(dx[i], drm[i], 1'b1);
            eu   = ref_model(dx[i], drm[i], 1'b0);
            es.y = dys[i];
            eu.y = dyu[i];
            send(dx[i], drm[i], es, eu);
        end
        drain();

        rnd_mode = 1'b1;
        for (int i = 0; i < 64; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       rx = $urandom;
                1:       rx = $urandom >> $urandom_range(0, 31);
                2:       rx = -($urandom >> $urandom_range(8, 31));
                default: rx = ($urandom | 32'h01000000) & 32'h01FFFFFF;
            endcase
            send_m(rx, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_mode = 1'b0;

        or_fix = 1'b0;
        send_m(32'h00000064, 1'b0);
        send_m(32'hFFFF0001, 1'b1);
        send_m(32'h12345678, 1'b1);
        rstn = 1'b0;
        sb[0].delete();
        sb[1].delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post_rst_out_valid_dut%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("post_rst_in_ready_dut%0d", k), 32'(irdy[k]), 32'd1);
        end
        @(posedge clk);
        #1;
        or_fix = 1'b1;
        latency_probe(32'hFEDCBA98, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
